// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared helpers and default thresholds for the parametrised
//                single-clock FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    // Default geometry and threshold margins
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_DEPTH     = 32;
    localparam int DEF_AF_MARGIN = 4;
    localparam int DEF_AE_LEVEL  = 4;

    // Address width for n entries; never returns 0 so a 1-bit pointer
    // still exists for the smallest legal FIFO.
    function automatic int clog2_safe(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ram
//  Description : Simple dual-port storage array, one synchronous write port
//                and one unregistered read port. No reset on the contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = clog2_safe(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: store one word per enabled edge
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port is address-driven; the owner registers the result
    assign rdata = mem[raddr];

endmodule : fifo_ram
`default_nettype wire

// File: rtl/fifo_param.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_param
//  Description : Single-clock FIFO with parametrised width/depth, programmable
//                almost-full/almost-empty levels, sticky overflow/underflow
//                flags, synchronous flush and a registered read data output.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - DEF_AF_MARGIN,
    parameter int AE_LEVEL = DEF_AE_LEVEL,
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             clr_err,
    input  logic             write,
    input  logic             read,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    usedw,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow,
    output logic             underflow
);

    localparam int          AW      = clog2_safe(DEPTH);
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_AF    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] C_AE    = CW'(AE_LEVEL);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    usedw_q, usedw_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             ram_we;
    logic [WIDTH-1:0] ram_rdata;

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (din),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    // Status flags decode directly from the occupancy counter
    assign full         = (usedw_q == C_DEPTH);
    assign empty        = (usedw_q == '0);
    assign almost_full  = (usedw_q >= C_AF);
    assign almost_empty = (usedw_q <= C_AE);
    assign usedw        = usedw_q;
    assign dout         = dout_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Next-state: pointer/counter/data update plus sticky error handling
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        usedw_d     = usedw_q;
        dout_d      = dout_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        ram_we      = 1'b0;

        // Clear first so an error raised on the same edge takes priority
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            usedw_d  = '0;
        end else begin
            case ({write, read})
                2'b10: begin
                    if (full) begin
                        overflow_d = 1'b1;
                    end else begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        usedw_d  = usedw_q + CW'(1);
                    end
                end
                2'b01: begin
                    if (empty) begin
                        underflow_d = 1'b1;
                    end else begin
                        dout_d   = ram_rdata;
                        rd_ptr_d = rd_ptr_q + AW'(1);
                        usedw_d  = usedw_q - CW'(1);
                    end
                end
                2'b11: begin
                    if (empty) begin
                        // Nothing stored yet: hand the incoming word straight out
                        dout_d = din;
                    end else begin
                        // Read side sees the old word even when both pointers
                        // address the same slot on a full FIFO
                        dout_d   = ram_rdata;
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        rd_ptr_d = rd_ptr_q + AW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            usedw_q     <= '0;
            dout_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            usedw_q     <= usedw_d;
            dout_q      <= dout_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

`ifndef SYNTHESIS
    a_usedw_range: assert property (@(posedge clk) disable iff (!reset)
        usedw_q <= C_DEPTH);
    a_full_empty_excl: assert property (@(posedge clk) disable iff (!reset)
        !(full && empty));
`ifdef FIFO_STRICT_PROTOCOL
    // Protocol misuse is otherwise legal and recorded by the sticky flags;
    // these two are only for integrations that treat it as fatal.
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(write && full && !read && !flush));
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
        !(read && empty && !write && !flush));
`endif
`endif

endmodule : fifo_param
`default_nettype wire

// File: doc/fifo_param.md
Name: fifo_param

Overview:
Synchronous single-clock FIFO with parametrised data width and depth. It replaces the fixed 8-bit x 32 queue model with synthesizable RAM-plus-pointer logic. It adds programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush. It sits between producer and consumer blocks in the same clock domain.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 32, number of entries; power of two, >=2
AF_LEVEL, DEPTH-4, almost_full asserted when usedw >= AF_LEVEL
AE_LEVEL, 4, almost_empty asserted when usedw <= AE_LEVEL
CW (localparam), $clog2(DEPTH)+1, count width so that DEPTH itself is representable

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous clear of contents and pointers (errors kept)
clr_err  in  1  synchronous clear of overflow/underflow
write  in  1  write request
read  in  1  read request
din  in  WIDTH  write data
dout  out  WIDTH  read data, registered
usedw  out  CW  current occupancy, 0..DEPTH
full  out  1  usedw == DEPTH
empty  out  1  usedw == 0
almost_full  out  1  usedw >= AF_LEVEL
almost_empty  out  1  usedw <= AE_LEVEL
overflow  out  1  sticky: write attempted while full without read
underflow  out  1  sticky: read attempted while empty without write

Behaviour:
- Reset (reset=0, async): wr_ptr=rd_ptr=0, usedw=0, dout=0, overflow=underflow=0. Hence empty=1, almost_empty=1, full=0, almost_full=0. RAM contents are not cleared.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. usedw is a separate CW-bit counter.
- Status flags are combinational from usedw.
- Read latency is one cycle. On an accepted read at edge N, dout takes the head entry after edge N and holds until the next accepted read.
- Per-edge cases, applied when flush=0:
  - write only, not full: mem[wr_ptr]<=din; wr_ptr++; usedw++.
  - write only, full: no state change except overflow<=1.
  - read only, not empty: dout<=mem[rd_ptr]; rd_ptr++; usedw--.
  - read only, empty: dout holds; underflow<=1.
  - read+write, empty: pass-through. dout<=din; pointers and usedw unchanged; no error.
  - read+write, 0<usedw<=DEPTH (including full): dout<=mem[rd_ptr]; mem[wr_ptr]<=din; both pointers ++; usedw unchanged; no overflow.
- flush=1: wr_ptr=rd_ptr=usedw=0; read/write that cycle are ignored; dout holds; error flags hold.
- Error flags: clr_err=1 clears both flags. If a new error occurs on the same edge as clr_err, the set wins.
- There is no state machine beyond the counter and pointers.
- Reset asserted mid-operation aborts immediately to the reset values.
- Assertions, inside synthesis translate_off:
  - never write&&full&&!read;
  - never read&&empty&&!write;
  - usedw <= DEPTH always;
  - full and empty never both 1.

Decomposition:
- Package fifo_pkg: function clog2_safe and the default threshold constants.
- One sub-module, fifo_ram: simple dual-port memory with WIDTH x DEPTH storage, one write port and one registered-free read address. It lets the array map to block RAM.
- fifo_param contains the pointers, counter, flags, dout register and assertions.

Test Plan:
- Reset, then 32 writes of 0x00..0x1F with no reads -> usedw goes 1..32. almost_full rises after the 28th write, full after the 32nd. overflow stays 0.
- From full, 32 reads -> dout is 0x00..0x1F in order, one cycle after each read. empty=1 at the end. almost_empty rises when usedw reaches 4.
- Simultaneous read+write on empty with din=0xA5 -> next cycle dout=0xA5, usedw=0, no error. Same on full: usedw stays 32, dout = oldest entry, overflow=0.
- Write when full without read, then read when empty without write -> overflow=1 and underflow=1, both sticky across 10 idle cycles. clr_err clears both to 0.
- 20 writes, 20 reads, repeated 3 times -> pointer wrap keeps FIFO order. usedw returns to 0 each pass.
- Fill 10 entries, flush -> usedw=0, empty=1. Assert reset for 1 cycle mid-burst -> all outputs at reset values asynchronously.
